// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command-frame parser and its helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_PAYLOAD,
    ST_CSUM,
    ST_TRL0,
    ST_TRL1,
    ST_COMMIT
  } parser_state_t;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_TYPE = 3'd1;
  localparam logic [2:0] ERR_CSUM = 3'd2;
  localparam logic [2:0] ERR_TRL  = 3'd3;
  localparam logic [2:0] ERR_TMO  = 3'd4;

  localparam logic [3:0] ACK_NIB  = 4'hA;
  localparam logic [3:0] NACK_NIB = 4'hE;

  localparam logic [7:0] HDR0_DEFAULT = 8'h00;
  localparam logic [7:0] END0_DEFAULT = 8'hFF;
  localparam logic [7:0] END1_DEFAULT = 8'h00;

  function automatic logic [7:0] ack_byte(input logic [3:0] pkt_type);
    return {ACK_NIB, pkt_type};
  endfunction

  function automatic logic [7:0] nack_byte(input logic [2:0] code);
    return {NACK_NIB, 1'b0, code};
  endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Idle-cycle watchdog: counts enabled cycles without a clear and pulses
// expire on the cycle the count reaches TIMEOUT_CYCLES-1.
module uart_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // A clear on the expiry cycle wins, so a late byte still keeps the frame alive.
  assign expire = en && !clr && (cnt == LAST);

  // Count while enabled; restart on clear, disable or expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clr || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: HDR0, type, payload, optional XOR checksum,
// END0, END1. Commits packets, reports aborts and queues an ACK/NACK byte.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int                      NUM_TYPES      = 4,
  parameter int                      MAX_PAYLOAD    = 16,
  parameter logic [5*NUM_TYPES-1:0]  PAYLOAD_LEN    = {5'd0, 5'd2, 5'd5, 5'd9},
  parameter logic [7:0]              HDR0           = HDR0_DEFAULT,
  parameter logic [7:0]              END0           = END0_DEFAULT,
  parameter logic [7:0]              END1           = END1_DEFAULT,
  parameter bit                      CSUM_EN        = 1'b1,
  parameter bit                      ACK_EN         = 1'b1,
  parameter int                      TIMEOUT_CYCLES = 5000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  output logic                     pkt_valid,
  output logic [3:0]               pkt_type,
  output logic [4:0]               pkt_len,
  output logic [MAX_PAYLOAD*8-1:0] pkt_payload,
  output logic                     err_valid,
  output logic [2:0]               err_code
);

  parser_state_t state;

  logic [3:0] type_q;
  logic [4:0] len_q;
  logic [4:0] idx_q;
  logic [7:0] csum_q;
  logic [7:0] pay_buf [MAX_PAYLOAD];

  logic                     type_ok;
  logic [4:0]               lut_len;
  logic                     abort;
  logic [2:0]               abort_code;
  logic                     commit;
  logic                     tmo_en;
  logic                     tmo_expire;
  logic [MAX_PAYLOAD*8-1:0] payload_masked;

  // The watchdog only runs while a frame is in flight.
  assign tmo_en = (state != ST_IDLE) && (state != ST_COMMIT);

  uart_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tmo_en),
    .clr   (rx_valid),
    .expire(tmo_expire)
  );

  // Validate the incoming type byte and look up its payload length.
  always_comb begin
    type_ok = (rx_data[7:4] == 4'h0) && ({1'b0, rx_data[3:0]} < 5'(NUM_TYPES));
    lut_len = 5'd0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      if (rx_data[3:0] == 4'(i)) lut_len = PAYLOAD_LEN[5*i +: 5];
    end
  end

  // Present only the first len bytes; stale buffer bytes beyond len read as zero.
  always_comb begin
    payload_masked = '0;
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      payload_masked[8*i +: 8] = (5'(i) < len_q) ? pay_buf[i] : 8'h00;
    end
  end

  // Decide whether this cycle ends the frame, either by abort or by commit.
  always_comb begin
    abort      = 1'b0;
    abort_code = ERR_NONE;
    commit     = 1'b0;
    if (tmo_expire) begin
      abort      = 1'b1;
      abort_code = ERR_TMO;
    end else if (rx_valid) begin
      case (state)
        ST_TYPE: begin
          if (!type_ok) begin
            abort      = 1'b1;
            abort_code = ERR_TYPE;
          end
        end
        ST_CSUM: begin
          if (rx_data != csum_q) begin
            abort      = 1'b1;
            abort_code = ERR_CSUM;
          end
        end
        ST_TRL0: begin
          if (rx_data != END0) begin
            abort      = 1'b1;
            abort_code = ERR_TRL;
          end
        end
        ST_TRL1: begin
          if (rx_data != END1) begin
            abort      = 1'b1;
            abort_code = ERR_TRL;
          end else begin
            commit = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame state machine with registered packet, error and ACK-slot outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      type_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      for (int i = 0; i < MAX_PAYLOAD; i++) pay_buf[i] <= '0;
      pkt_valid   <= 1'b0;
      pkt_type    <= '0;
      pkt_len     <= '0;
      pkt_payload <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
    end else begin
      pkt_valid <= 1'b0;
      err_valid <= 1'b0;
      if (tx_valid && tx_ready) tx_valid <= 1'b0;

      if (abort) begin
        state     <= ST_IDLE;
        err_valid <= 1'b1;
        err_code  <= abort_code;
        if (ACK_EN && !tx_valid) begin
          tx_valid <= 1'b1;
          tx_data  <= nack_byte(abort_code);
        end
      end else if (commit) begin
        state       <= ST_COMMIT;
        pkt_valid   <= 1'b1;
        pkt_type    <= type_q;
        pkt_len     <= len_q;
        pkt_payload <= payload_masked;
        if (ACK_EN && !tx_valid) begin
          tx_valid <= 1'b1;
          tx_data  <= ack_byte(type_q);
        end
      end else if (rx_valid) begin
        case (state)
          ST_IDLE, ST_COMMIT: begin
            if (rx_data == HDR0) begin
              state <= ST_TYPE;
              idx_q <= 5'd0;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_TYPE: begin
            type_q <= rx_data[3:0];
            len_q  <= lut_len;
            csum_q <= rx_data;
            if (lut_len != 5'd0) state <= ST_PAYLOAD;
            else if (CSUM_EN) state <= ST_CSUM;
            else state <= ST_TRL0;
          end
          ST_PAYLOAD: begin
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
              if (idx_q == 5'(i)) pay_buf[i] <= rx_data;
            end
            csum_q <= csum_q ^ rx_data;
            idx_q  <= idx_q + 5'd1;
            if (idx_q == len_q - 5'd1) begin
              if (CSUM_EN) state <= ST_CSUM;
              else state <= ST_TRL0;
            end
          end
          ST_CSUM: state <= ST_TRL0;
          ST_TRL0: state <= ST_TRL1;
          default: state <= ST_IDLE;
        endcase
      end else if (state == ST_COMMIT) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (timeout shortened to 100).
module tb_uart_cmd_parser;

  logic         clk;
  logic         rst_n;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [7:0]   tx_data;
  logic         pkt_valid;
  logic [3:0]   pkt_type;
  logic [4:0]   pkt_len;
  logic [127:0] pkt_payload;
  logic         err_valid;
  logic [2:0]   err_code;

  int checks;
  int errors;
  int pkt_cnt;
  int err_cnt;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .pkt_valid  (pkt_valid),
    .pkt_type   (pkt_type),
    .pkt_len    (pkt_len),
    .pkt_payload(pkt_payload),
    .err_valid  (err_valid),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count packet and error pulses seen over the whole run.
  always @(posedge clk) begin
    if (pkt_valid) pkt_cnt++;
    if (err_valid) err_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one byte for one clock; returns at the negedge after it was sampled.
  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Send n bytes back to back, first byte in the most significant position.
  task automatic applyFrame(input logic [127:0] bytes, input int n);
    for (int i = 0; i < n; i++) applyStimulus(bytes[8*(n-1-i) +: 8]);
  endtask

  localparam logic [127:0] GOOD_T1 = 128'h00_01_07_80_04_38_02_B8_FF_00;
  localparam logic [127:0] GOOD_T1_PAY = 128'h02_38_04_80_07;
  localparam logic [127:0] ZERO_T3 = 128'h00_03_03_FF_00;

  int early;
  int snap;

  initial begin
    checks   = 0;
    errors   = 0;
    pkt_cnt  = 0;
    err_cnt  = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_pkt_valid", 128'(pkt_valid), 0);
    checkOutput("rst_pkt_type", 128'(pkt_type), 0);
    checkOutput("rst_pkt_len", 128'(pkt_len), 0);
    checkOutput("rst_payload", pkt_payload, 0);
    checkOutput("rst_err", {err_valid, err_code}, 0);
    checkOutput("rst_tx", {tx_valid, tx_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] good type-1 frame");
    applyFrame(GOOD_T1, 10);
    checkOutput("good_pkt_valid", 128'(pkt_valid), 1);
    checkOutput("good_pkt_type", 128'(pkt_type), 1);
    checkOutput("good_pkt_len", 128'(pkt_len), 5);
    checkOutput("good_payload", pkt_payload, GOOD_T1_PAY);
    checkOutput("good_ack", {tx_valid, tx_data}, {1'b1, 8'hA1});
    checkOutput("good_no_err", 128'(err_valid), 0);
    @(negedge clk);
    checkOutput("good_pulse_1cyc", 128'(pkt_valid), 0);
    checkOutput("good_tx_drop", 128'(tx_valid), 0);

    $display("[TB] bad checksum");
    applyFrame(128'h00_01_07_80_04_38_02_00, 8);
    checkOutput("csum_err", {err_valid, err_code}, {1'b1, 3'd2});
    checkOutput("csum_nack", {tx_valid, tx_data}, {1'b1, 8'hE2});
    checkOutput("csum_pkt_kept", {pkt_valid, pkt_type, pkt_len}, {1'b0, 4'd1, 5'd5});
    checkOutput("csum_payload_kept", pkt_payload, GOOD_T1_PAY);

    $display("[TB] bad types");
    applyFrame(128'h00_05, 2);
    checkOutput("type5_err", {err_valid, err_code}, {1'b1, 3'd1});
    checkOutput("type5_nack", {tx_valid, tx_data}, {1'b1, 8'hE1});
    @(negedge clk);
    applyFrame(128'h00_04, 2);
    checkOutput("type4_err", {err_valid, err_code}, {1'b1, 3'd1});
    @(negedge clk);

    // With the default length table the zero-length type is 3.
    $display("[TB] zero-length frame");
    applyFrame(ZERO_T3, 5);
    checkOutput("zlen_pkt", {pkt_valid, pkt_type, pkt_len}, {1'b1, 4'd3, 5'd0});
    checkOutput("zlen_payload", pkt_payload, 0);
    checkOutput("zlen_ack", {tx_valid, tx_data}, {1'b1, 8'hA3});
    @(negedge clk);

    $display("[TB] trailer errors");
    applyFrame(128'h00_03_03_FE, 4);
    checkOutput("trl0_err", {err_valid, err_code, tx_data}, {1'b1, 3'd3, 8'hE3});
    @(negedge clk);
    applyFrame(128'h00_03_03_FF_01, 5);
    checkOutput("trl1_err", {err_valid, err_code, pkt_valid}, {1'b1, 3'd3, 1'b0});
    @(negedge clk);

    $display("[TB] timeout");
    applyFrame(128'h00_02_11, 3);
    early = 0;
    repeat (99) begin
      @(negedge clk);
      if (err_valid) early = 1;
    end
    checkOutput("tmo_not_early", 128'(early), 0);
    @(negedge clk);
    checkOutput("tmo_err", {err_valid, err_code}, {1'b1, 3'd4});
    checkOutput("tmo_nack", {tx_valid, tx_data}, {1'b1, 8'hE4});
    @(negedge clk);

    $display("[TB] byte on expiry cycle");
    applyFrame(128'h00_02_11, 3);
    repeat (99) @(negedge clk);
    snap = err_cnt;
    applyFrame(128'h22_31_FF_00, 4);
    checkOutput("tmo_race_pkt", {pkt_valid, pkt_type, pkt_len}, {1'b1, 4'd2, 5'd2});
    checkOutput("tmo_race_payload", pkt_payload, 128'h2211);
    checkOutput("tmo_race_ack", tx_data, 8'hA2);
    repeat (2) @(negedge clk);
    checkOutput("tmo_race_no_abort", 128'(err_cnt - snap), 0);

    $display("[TB] transmit backpressure");
    tx_ready = 1'b0;
    snap = pkt_cnt;
    applyFrame(ZERO_T3, 5);
    checkOutput("bp_first_ack", {tx_valid, tx_data}, {1'b1, 8'hA3});
    applyFrame(GOOD_T1, 10);
    checkOutput("bp_second_pkt", {pkt_valid, pkt_type}, {1'b1, 4'd1});
    checkOutput("bp_second_dropped", {tx_valid, tx_data}, {1'b1, 8'hA3});
    repeat (5) @(negedge clk);
    checkOutput("bp_hold", {tx_valid, tx_data}, {1'b1, 8'hA3});
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checkOutput("bp_released", 128'(tx_valid), 0);
    @(negedge clk);
    checkOutput("bp_slot_empty", 128'(tx_valid), 0);
    checkOutput("bp_pkt_count", 128'(pkt_cnt - snap), 2);
    tx_ready = 1'b1;

    $display("[TB] reset mid-frame");
    snap = err_cnt;
    applyFrame(128'h00_01_07, 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_pkt", {pkt_valid, pkt_type, pkt_len}, 0);
    checkOutput("midrst_payload", pkt_payload, 0);
    checkOutput("midrst_err", {err_valid, err_code}, 0);
    checkOutput("midrst_tx", {tx_valid, tx_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_no_err_pulse", 128'(err_cnt - snap), 0);
    applyFrame(GOOD_T1, 10);
    checkOutput("after_rst_pkt", {pkt_valid, pkt_type, pkt_len}, {1'b1, 4'd1, 5'd5});
    checkOutput("after_rst_payload", pkt_payload, GOOD_T1_PAY);
    checkOutput("after_rst_ack", {tx_valid, tx_data}, {1'b1, 8'hA1});
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
